// File: rtl/pattern_gen_serial_pkg.sv
// Shared types and constants for the serial pattern generator
// and its companion 1101 detector.
package pattern_gen_serial_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [3:0] PAT_1101 = 4'b1101;

endpackage

// File: rtl/pattern_gen_serial_if.sv
// Request/stream bundle between a pattern source and the generator.
interface pattern_gen_serial_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 4
);
   logic             start;
   logic [WIDTH-1:0] pattern;
   logic [CNT_W-1:0] repeat_n;
   logic             dout;
   logic             valid;
   logic             busy;
   logic             done;

   modport master (
      output start, pattern, repeat_n,
      input  dout, valid, busy, done
   );

   modport slave (
      input  start, pattern, repeat_n,
      output dout, valid, busy, done
   );
endinterface

// File: rtl/pattern_gen_serial_shift.sv
// WIDTH-bit parallel-load, left-shift register; msb is the next
// bit to leave the link.
module pattern_shift_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   output logic             msb
);

   logic [WIDTH-1:0] shreg_q;
   logic [WIDTH-1:0] shreg_d;

   always_comb begin
      shreg_d = shreg_q;
      if (load) begin
         shreg_d = din;
      end else if (shift) begin
         shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg_q <= '0;
      end else begin
         shreg_q <= shreg_d;
      end
   end

   assign msb = shreg_q[WIDTH-1];

endmodule

// File: rtl/pattern_gen_serial.sv
// Serial pattern transmitter: sends a captured pattern MSB-first,
// repeat_n times, with optional idle gaps between repetitions.
module pattern_gen_serial
   import pattern_gen_serial_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int CNT_W   = 4,
   parameter int GAP_LEN = 0
) (
   input logic                 clk,
   input logic                 rst,
   pattern_gen_serial_if.slave bus
);

   localparam int BW = $clog2(WIDTH);
   localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
   logic             dout_q, dout_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             sh_load;
   logic             sh_shift;
   logic [WIDTH-1:0] sh_din;
   logic             sh_msb;

   // The register holds the bits still to send after the one on dout.
   pattern_shift_reg #(.WIDTH(WIDTH)) u_shreg (
      .clk   (clk),
      .rst   (rst),
      .load  (sh_load),
      .shift (sh_shift),
      .din   (sh_din),
      .msb   (sh_msb)
   );

   always_comb begin
      state_d   = state_q;
      pat_d     = pat_q;
      rep_cnt_d = rep_cnt_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      dout_d    = 1'b0;
      valid_d   = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      sh_load   = 1'b0;
      sh_shift  = 1'b0;
      sh_din    = {pat_q[WIDTH-2:0], 1'b0};

      case (state_q)
         ST_IDLE: begin
            if (bus.start && bus.repeat_n != '0) begin
               pat_d     = bus.pattern;
               rep_cnt_d = bus.repeat_n;
               bit_cnt_d = BW'(WIDTH-1);
               sh_load   = 1'b1;
               sh_din    = {bus.pattern[WIDTH-2:0], 1'b0};
               dout_d    = bus.pattern[WIDTH-1];
               valid_d   = 1'b1;
               busy_d    = 1'b1;
               state_d   = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            busy_d = 1'b1;
            if (bit_cnt_q != '0) begin
               bit_cnt_d = bit_cnt_q - BW'(1);
               sh_shift  = 1'b1;
               dout_d    = sh_msb;
               valid_d   = 1'b1;
            end else if (rep_cnt_q == CNT_W'(1)) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else if (GAP_LEN > 0) begin
               rep_cnt_d = rep_cnt_q - CNT_W'(1);
               gap_cnt_d = GW'(GAP_LEN-1);
               state_d   = ST_GAP;
            end else begin
               rep_cnt_d = rep_cnt_q - CNT_W'(1);
               bit_cnt_d = BW'(WIDTH-1);
               sh_load   = 1'b1;
               dout_d    = pat_q[WIDTH-1];
               valid_d   = 1'b1;
            end
         end

         ST_GAP: begin
            busy_d = 1'b1;
            if (gap_cnt_q == '0) begin
               bit_cnt_d = BW'(WIDTH-1);
               sh_load   = 1'b1;
               dout_d    = pat_q[WIDTH-1];
               valid_d   = 1'b1;
               state_d   = ST_SHIFT;
            end else begin
               gap_cnt_d = gap_cnt_q - GW'(1);
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         pat_q     <= '0;
         rep_cnt_q <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         dout_q    <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pat_q     <= pat_d;
         rep_cnt_q <= rep_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         dout_q    <= dout_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.dout  = dout_q;
   assign bus.valid = valid_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;

endmodule
